// File: rtl/gen_multi_tick.sv
// Multi-channel tick / clock-enable generator: shared prescaler plus NCH reloadable dividers.
// Define GEN_MULTI_TICK_SQUARE_EN to build the per-channel square-wave CK outputs.
module gen_multi_tick #(
  parameter int unsigned         PRE_DIV  = 10000,
  parameter int unsigned         NCH      = 4,
  parameter int unsigned         DW       = 16,
  parameter logic [NCH*DW-1:0]   DIV_INIT = {16'd10000, 16'd1000, 16'd100, 16'd10},
  localparam int unsigned        CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLOCK,
  input  logic           RESET,
  input  logic           EN,
  input  logic           SYNC,
  input  logic           LD_VALID,
  output logic           LD_READY,
  input  logic [CW-1:0]  LD_CH,
  input  logic [DW-1:0]  LD_DIV,
  output logic           BASE_TICK,
  output logic [NCH-1:0] TICK,
  output logic [NCH-1:0] CK
);

  localparam int unsigned PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  logic [PW-1:0]          pre_cnt;
  logic                   pre_last;
  logic                   be;

  logic [NCH-1:0][DW-1:0] div_q;
  logic [NCH-1:0][DW-1:0] shd_q;
  logic [NCH-1:0][DW-1:0] cnt_q;
  logic [NCH-1:0][DW-1:0] eff;
  logic [NCH-1:0]         pend_q;
  logic [NCH-1:0]         wrap;
  logic [NCH-1:0]         ld_sel;
  logic                   sel_pend;

  assign pre_last = (pre_cnt == PW'(PRE_DIV - 1));
  assign be       = EN & ~SYNC & pre_last;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pre_cnt   <= '0;
      BASE_TICK <= 1'b0;
    end else begin
      BASE_TICK <= be;
      if (SYNC)
        pre_cnt <= '0;
      else if (EN)
        pre_cnt <= pre_last ? '0 : pre_cnt + PW'(1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      eff[i]  = (div_q[i] == '0) ? DW'(1) : div_q[i];
      wrap[i] = (cnt_q[i] == eff[i] - DW'(1));
    end
  end

  // Out-of-range LD_CH matches no channel, so it reads as not pending and is dropped.
  always_comb begin
    sel_pend = 1'b0;
    ld_sel   = '0;
    for (int unsigned i = 0; i < NCH; i++)
      if (32'(LD_CH) == i) sel_pend = pend_q[i];
    LD_READY = ~SYNC & ~sel_pend;
    for (int unsigned i = 0; i < NCH; i++)
      ld_sel[i] = LD_VALID & LD_READY & (32'(LD_CH) == i);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt_q  <= '0;
      shd_q  <= '0;
      pend_q <= '0;
      div_q  <= DIV_INIT;
      TICK   <= '0;
    end else begin
      TICK <= {NCH{be}} & wrap;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (SYNC)
          cnt_q[i] <= '0;
        else if (be)
          cnt_q[i] <= wrap[i] ? '0 : cnt_q[i] + DW'(1);
        // A channel is only loadable while not pending, so apply and load never collide.
        if ((SYNC || (be && wrap[i])) && pend_q[i]) begin
          div_q[i]  <= shd_q[i];
          pend_q[i] <= 1'b0;
        end else if (ld_sel[i]) begin
          shd_q[i]  <= LD_DIV;
          pend_q[i] <= 1'b1;
        end
      end
    end
  end

`ifdef GEN_MULTI_TICK_SQUARE_EN
  logic [NCH-1:0] ck_q;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ck_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (SYNC || (eff[i] == DW'(1)))
          ck_q[i] <= 1'b0;
        else if (be) begin
          if (wrap[i])
            ck_q[i] <= 1'b0;
          else if (cnt_q[i] + DW'(1) == (eff[i] >> 1))
            ck_q[i] <= 1'b1;
        end
      end
    end
  end

  assign CK = ck_q;
`else
  assign CK = '0;
`endif

endmodule
